// File: rtl/slink_link_ctrl.sv
// Serial link power/isolation sequencer.
// Orders clock, reset and isolation; gates AXI while not UP.
module slink_link_ctrl #(
   parameter int unsigned ClkSettleCycles = 8,
   parameter int unsigned RstCycles       = 16,
   parameter int unsigned TimeoutCycles   = 1024
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic       clr_err_i,
   input  logic       drain_idle_i,
   input  logic       isolated_i,
   output logic       clk_ena_o,
   output logic       link_rst_no,
   output logic       isolate_o,
   output logic       axi_gate_o,
   output logic       link_up_o,
   output logic       err_o,
   output logic [3:0] state_o
);

   localparam int unsigned MaxA =
      (ClkSettleCycles > RstCycles) ?
      ClkSettleCycles : RstCycles;
   localparam int unsigned MaxCyc =
      (MaxA > TimeoutCycles) ? MaxA : TimeoutCycles;
   localparam int unsigned CntWidth = $clog2(MaxCyc) + 1;

   localparam logic [CntWidth-1:0] SettleLast =
      CntWidth'(ClkSettleCycles - 1);
   localparam logic [CntWidth-1:0] RstLast =
      CntWidth'(RstCycles - 1);
   localparam logic [CntWidth-1:0] ToLast =
      CntWidth'(TimeoutCycles - 1);

   typedef enum logic [3:0] {
      ST_OFF      = 4'd0,
      ST_CLK_ON   = 4'd1,
      ST_RST_REL  = 4'd2,
      ST_DEISO    = 4'd3,
      ST_UP       = 4'd4,
      ST_DRAIN    = 4'd5,
      ST_ISO      = 4'd6,
      ST_RST_ASRT = 4'd7,
      ST_ERR      = 4'd8
   } state_e;

   state_e              state_q, state_d;
   logic [CntWidth-1:0] cnt_q;
   logic                err_q;
   logic                to_hit;
   logic [4:0]          outs;

   assign to_hit = (cnt_q >= ToLast);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= (state_d == ST_ERR);
         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Success conditions are tested before the timeout limit.
   always_comb begin
      state_d = state_q;
      outs    = 5'b00110;
      unique case (state_q)
         ST_OFF: begin
            outs = 5'b00110;
            if (en_i) state_d = ST_CLK_ON;
         end
         ST_CLK_ON: begin
            outs = 5'b10110;
            if (cnt_q >= SettleLast) state_d = ST_RST_REL;
         end
         ST_RST_REL: begin
            outs = 5'b11110;
            if (cnt_q >= RstLast) state_d = ST_DEISO;
         end
         ST_DEISO: begin
            outs = 5'b11010;
            if (!isolated_i)  state_d = ST_UP;
            else if (to_hit)  state_d = ST_ERR;
         end
         ST_UP: begin
            outs = 5'b11001;
            if (!en_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            outs = 5'b11010;
            if (drain_idle_i) state_d = ST_ISO;
            else if (to_hit)  state_d = ST_ERR;
         end
         ST_ISO: begin
            outs = 5'b11110;
            if (isolated_i)  state_d = ST_RST_ASRT;
            else if (to_hit) state_d = ST_ERR;
         end
         ST_RST_ASRT: begin
            outs    = 5'b10110;
            state_d = ST_OFF;
         end
         ST_ERR: begin
            outs = 5'b00110;
            if (clr_err_i) state_d = ST_OFF;
         end
         default: begin
            outs    = 5'b00110;
            state_d = ST_OFF;
         end
      endcase
   end

   assign clk_ena_o   = outs[4];
   assign link_rst_no = outs[3];
   assign isolate_o   = outs[2];
   assign axi_gate_o  = outs[1];
   assign link_up_o   = outs[0];
   assign err_o       = err_q;
   assign state_o     = state_q;

   a_params: assert property (@(posedge clk_i)
      ClkSettleCycles >= 1 && RstCycles >= 1 &&
      TimeoutCycles >= 1);

   a_up_safe: assert property (@(posedge clk_i)
      disable iff (!rst_ni)
      link_up_o |-> (!isolate_o && link_rst_no));

   a_clk_rst: assert property (@(posedge clk_i)
      disable iff (!rst_ni)
      !clk_ena_o |-> !link_rst_no);

endmodule
